input_conditioner: RTL and testbench
====================================

// Module: input_conditioner
//
// PURPOSE
// - Multi-channel conditioner for raw board inputs (switches, buttons, strobes).
// - Each channel is synchronised, debounced and edge-detected in one block.
// - Outputs clean levels plus one-cycle rise/fall/changed pulses.
// - Sits directly behind the pins in the clk domain, downstream of reset_sync.
//
// PARAMETERS
// - Channels    4    number of independent input channels (>=1)
// - Period      100  clk cycles a synced input must differ continuously before accepted (>=1)
// - SyncStages  2    synchroniser flops per channel (>=2)
// - ResetValue  '0   Channels-bit reset level of sync chain and sig_o
//
// PORTS
// - clk        in   1         main clock
// - rst        in   1         asynchronous, active-high reset
// - sig_i      in   Channels  raw asynchronous inputs
// - sig_o      out  Channels  debounced level
// - rise_o     out  Channels  1-cycle pulse, sig_o[i] went 0->1
// - fall_o     out  Channels  1-cycle pulse, sig_o[i] went 1->0
// - changed_o  out  Channels  rise_o | fall_o
// - clear_i    in   Channels  clears event_o[i] (latch feature only)
// - event_o    out  Channels  sticky edge flag (latch feature only)
//
// BEHAVIOUR
// - Reset (async assert, all flops): sync chain = ResetValue, sig_o = ResetValue,
//   counters = 0, rise_o/fall_o/changed_o = 0, event_o = 0.
// - Sync: s[i] = last stage of SyncStages-flop chain on sig_i[i].
// - Per-channel counter, width $clog2(Period+1); per-channel state, every edge:
//   - s == sig_o          : cnt <= 0 (state STABLE)
//   - s != sig_o, cnt < Period-1 : cnt <= cnt+1 (state COUNTING)
//   - s != sig_o, cnt == Period-1: sig_o <= s, cnt <= 0, edge pulse (back to STABLE)
// - Glitch shorter than Period cycles at s: counter clears, no output change, no pulse.
// - Latency: sig_i change stable from edge 0 -> sig_o changes at edge SyncStages+Period.
// - Period == 1: pure synchroniser + edge detect, latency SyncStages+1.
// - rise_o/fall_o registered, asserted exactly the cycle sig_o takes its new value,
//   high for one cycle; rise and fall never both set for one channel.
// - Channels fully independent; simultaneous edges on several channels all reported.
// - Counter never exceeds Period-1; no wrap-around possible.
// - Reset mid-count: state discarded; after release, input differing from
//   ResetValue is debounced afresh and reported with a normal pulse.
// - No pulse is generated by reset assertion or release itself.
//
// CONFIGURATION
// - INPUT_COND_EVENT_LATCH_EN defined:
//   - event_o[i] <= 1 on changed_o[i]; cleared when clear_i[i] == 1 (registered, next edge).
//   - Same-cycle edge pulse and clear_i[i]: set wins, event_o[i] stays 1.
// - INPUT_COND_EVENT_LATCH_EN undefined:
//   - event_o tied to 0, clear_i ignored; ports still present, no flops inferred.
//
// TESTING
// - Reset: rst=1 with sig_i=4'hF, ResetValue=0 -> sig_o=0, all pulses 0; release,
//   hold sig_i -> sig_o=4'hF and rise_o=4'hF for 1 cycle at edge SyncStages+Period (102).
// - Glitch: Period=100, sig_i[0] high for 99 cycles then low -> sig_o[0] stays 0, no pulse.
// - Fall: sig_o[1]=1, sig_i[1] low held -> sig_o[1]=0 at edge 102, fall_o[1]=1 one cycle,
//   changed_o[1]=1 same cycle, rise_o=0.
// - Independence: sig_i[2] rises at t, sig_i[3] rises at t+10 -> rise_o[2] at t+102,
//   rise_o[3] at t+112, no cross-talk; Period=1 run: rise at t+3.
// - Mid-operation reset: sig_i[0] high 50 cycles, rst pulse, keep high -> no pulse during
//   reset, rise_o[0] 102 cycles after release.
// - Latch (macro on): rise on ch0 -> event_o[0]=1 sticky; clear_i[0]=1 same cycle as
//   new pulse -> stays 1; clear_i[0]=1 alone -> 0 next edge. Macro off: event_o==0 always.

Source files
------------

// File: rtl/input_conditioner.sv
// input_conditioner: per-channel synchroniser, debouncer and edge detector
// for raw board inputs in the clk domain.
//
// Ports:
//   clk        main clock
//   rst        asynchronous active-high reset
//   sig_i      raw asynchronous inputs, one bit per channel
//   sig_o      debounced level
//   rise_o     one-cycle pulse when sig_o[i] goes 0->1
//   fall_o     one-cycle pulse when sig_o[i] goes 1->0
//   changed_o  rise_o | fall_o
//   clear_i    clears event_o[i] (event latch build only)
//   event_o    sticky edge flag (event latch build only, else tied to 0)
//
// Optional feature: define INPUT_COND_EVENT_LATCH_EN to build the sticky
// event_o flags; otherwise event_o is constant 0 and clear_i is ignored.
module input_conditioner #(
    parameter int unsigned         Channels   = 4,
    parameter int unsigned         Period     = 100,
    parameter int unsigned         SyncStages = 2,
    parameter logic [Channels-1:0] ResetValue = '0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [Channels-1:0] sig_i,
    output logic [Channels-1:0] sig_o,
    output logic [Channels-1:0] rise_o,
    output logic [Channels-1:0] fall_o,
    output logic [Channels-1:0] changed_o,
    input  logic [Channels-1:0] clear_i,
    output logic [Channels-1:0] event_o
);

    localparam int unsigned CntW = $clog2(Period + 1);
    localparam logic [CntW-1:0] LastCnt = CntW'(Period - 1);

    typedef enum logic {
        ST_STABLE   = 1'b0,
        ST_COUNTING = 1'b1
    } state_t;

    logic [Channels-1:0] sync_q [SyncStages];
    logic [Channels-1:0] s;

    state_t              state_q [Channels];
    state_t              state_d [Channels];
    logic [CntW-1:0]     cnt_q   [Channels];
    logic [CntW-1:0]     cnt_d   [Channels];
    logic [Channels-1:0] level_d;
    logic [Channels-1:0] rise_d;
    logic [Channels-1:0] fall_d;

    // Synchroniser chain; the last stage is the metastability-safe sample.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int j = 0; j < SyncStages; j++) begin
                sync_q[j] <= ResetValue;
            end
        end else begin
            sync_q[0] <= sig_i;
            for (int j = 1; j < SyncStages; j++) begin
                sync_q[j] <= sync_q[j-1];
            end
        end
    end

    assign s = sync_q[SyncStages-1];

    // Debounce state, counters and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < Channels; i++) begin
                state_q[i] <= ST_STABLE;
                cnt_q[i]   <= '0;
            end
            sig_o     <= ResetValue;
            rise_o    <= '0;
            fall_o    <= '0;
            changed_o <= '0;
        end else begin
            for (int i = 0; i < Channels; i++) begin
                state_q[i] <= state_d[i];
                cnt_q[i]   <= cnt_d[i];
            end
            sig_o     <= level_d;
            rise_o    <= rise_d;
            fall_o    <= fall_d;
            changed_o <= rise_d | fall_d;
        end
    end

    // Per-channel next state: accept s only after it has differed from
    // sig_o on Period consecutive edges; any agreement restarts the count.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        level_d = sig_o;
        rise_d  = '0;
        fall_d  = '0;
        for (int i = 0; i < Channels; i++) begin
            case (state_q[i])
                ST_STABLE: begin
                    cnt_d[i] = '0;
                    if (s[i] != sig_o[i]) begin
                        if (LastCnt == '0) begin
                            // Period == 1: accept on the first differing edge.
                            level_d[i] = s[i];
                            rise_d[i]  = s[i];
                            fall_d[i]  = ~s[i];
                        end else begin
                            cnt_d[i]   = CntW'(1);
                            state_d[i] = ST_COUNTING;
                        end
                    end
                end
                ST_COUNTING: begin
                    if (s[i] == sig_o[i]) begin
                        cnt_d[i]   = '0;
                        state_d[i] = ST_STABLE;
                    end else if (cnt_q[i] == LastCnt) begin
                        level_d[i] = s[i];
                        rise_d[i]  = s[i];
                        fall_d[i]  = ~s[i];
                        cnt_d[i]   = '0;
                        state_d[i] = ST_STABLE;
                    end else begin
                        cnt_d[i] = cnt_q[i] + CntW'(1);
                    end
                end
                default: begin
                    cnt_d[i]   = '0;
                    state_d[i] = ST_STABLE;
                end
            endcase
        end
    end

`ifdef INPUT_COND_EVENT_LATCH_EN
    // Sticky edge flags; a new edge on the same edge as clear_i keeps the flag set.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            event_o <= '0;
        end else begin
            event_o <= (event_o & ~clear_i) | rise_d | fall_d;
        end
    end
`else
    logic unused_clear;
    assign unused_clear = ^clear_i;
    assign event_o      = '0;
`endif

endmodule

// File: tb/tb_input_conditioner.sv
module tb_input_conditioner;

    localparam int unsigned CH = 4;
    localparam int unsigned SS = 2;
    localparam int unsigned NI = 3;

    // Instance 0: Period 100, instance 1: Period 3, instance 2: Period 1.
    function automatic int period_of(input int k);
        case (k)
            0:       return 100;
            1:       return 3;
            default: return 1;
        endcase
    endfunction

    logic clk = 1'b0;
    logic rst;
    logic [CH-1:0] sig_i;
    logic [CH-1:0] clear_i;

    logic [NI-1:0][CH-1:0] so, ro, fo, co, eo;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    input_conditioner #(.Channels(CH), .Period(100), .SyncStages(SS)) dut0 (
        .clk(clk), .rst(rst), .sig_i(sig_i), .sig_o(so[0]), .rise_o(ro[0]),
        .fall_o(fo[0]), .changed_o(co[0]), .clear_i(clear_i), .event_o(eo[0]));

    input_conditioner #(.Channels(CH), .Period(3), .SyncStages(SS)) dut1 (
        .clk(clk), .rst(rst), .sig_i(sig_i), .sig_o(so[1]), .rise_o(ro[1]),
        .fall_o(fo[1]), .changed_o(co[1]), .clear_i(clear_i), .event_o(eo[1]));

    input_conditioner #(.Channels(CH), .Period(1), .SyncStages(SS)) dut2 (
        .clk(clk), .rst(rst), .sig_i(sig_i), .sig_o(so[2]), .rise_o(ro[2]),
        .fall_o(fo[2]), .changed_o(co[2]), .clear_i(clear_i), .event_o(eo[2]));

    // Reference model: each synced sample is the input seen SS edges earlier;
    // the level follows it once it has differed for Period consecutive edges.
    logic [NI-1:0][CH-1:0] m_out, m_rise, m_fall, m_evt;
    logic [CH-1:0] m_hist [NI][SS];
    int            m_run  [NI][CH];

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < NI; k++) begin
                for (int j = 0; j < SS; j++) m_hist[k][j] = '0;
                for (int i = 0; i < CH; i++) m_run[k][i] = 0;
            end
            m_out = '0; m_rise = '0; m_fall = '0; m_evt = '0;
        end else begin
            for (int k = 0; k < NI; k++) begin
                logic [CH-1:0] smp;
                smp = m_hist[k][SS-1];
                m_rise[k] = '0;
                m_fall[k] = '0;
                for (int i = 0; i < CH; i++) begin
                    if (smp[i] != m_out[k][i]) begin
                        m_run[k][i] = m_run[k][i] + 1;
                        if (m_run[k][i] >= period_of(k)) begin
                            m_out[k][i] = smp[i];
                            if (smp[i]) m_rise[k][i] = 1'b1;
                            else        m_fall[k][i] = 1'b1;
                            m_run[k][i] = 0;
                        end
                    end else begin
                        m_run[k][i] = 0;
                    end
                end
`ifdef INPUT_COND_EVENT_LATCH_EN
                m_evt[k] = (m_evt[k] & ~clear_i) | m_rise[k] | m_fall[k];
`else
                m_evt[k] = '0;
`endif
                for (int j = SS - 1; j > 0; j--) m_hist[k][j] = m_hist[k][j-1];
                m_hist[k][0] = sig_i;
            end
        end
    end

    task automatic chk(input string name, input logic [CH-1:0] got, input logic [CH-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic compare_all();
        for (int k = 0; k < NI; k++) begin
            chk($sformatf("model sig_o[%0d]", k),     so[k], m_out[k]);
            chk($sformatf("model rise_o[%0d]", k),    ro[k], m_rise[k]);
            chk($sformatf("model fall_o[%0d]", k),    fo[k], m_fall[k]);
            chk($sformatf("model changed_o[%0d]", k), co[k], m_rise[k] | m_fall[k]);
            chk($sformatf("model event_o[%0d]", k),   eo[k], m_evt[k]);
        end
    endtask

    // Advance one edge; drive and sample 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
        compare_all();
    endtask

    typedef struct {
        logic [CH-1:0] in;
        int            hold;
        logic [CH-1:0] exp_out;
        logic [CH-1:0] exp_rise;
        logic [CH-1:0] exp_fall;
    } vec_t;

    vec_t tbl [12];
    logic [CH-1:0] acc_r, acc_f;
    int hold;

    initial begin
        // Vectors for the Period-3 instance; edges are counted from each drive.
        tbl[0]  = '{4'h0, 8, 4'h0, 4'h0, 4'h0};
        tbl[1]  = '{4'h1, 2, 4'h0, 4'h0, 4'h0};
        tbl[2]  = '{4'h0, 8, 4'h0, 4'h0, 4'h0};
        tbl[3]  = '{4'h1, 8, 4'h1, 4'h1, 4'h0};
        tbl[4]  = '{4'h3, 4, 4'h1, 4'h0, 4'h0};
        tbl[5]  = '{4'h3, 8, 4'h3, 4'h2, 4'h0};
        tbl[6]  = '{4'hC, 8, 4'hC, 4'hC, 4'h3};
        tbl[7]  = '{4'hF, 2, 4'hC, 4'h0, 4'h0};
        tbl[8]  = '{4'hC, 8, 4'hC, 4'h0, 4'h0};
        tbl[9]  = '{4'h0, 8, 4'h0, 4'h0, 4'hC};
        tbl[10] = '{4'h5, 3, 4'h0, 4'h0, 4'h0};
        tbl[11] = '{4'h0, 8, 4'h0, 4'h5, 4'h5};

        rst = 1'b1; sig_i = 4'hF; clear_i = '0;

        // Reset with inputs high: everything held at the reset value.
        repeat (3) tick();
        for (int k = 0; k < NI; k++) begin
            chk("reset sig_o", so[k], 4'h0);
            chk("reset rise_o", ro[k], 4'h0);
            chk("reset fall_o", fo[k], 4'h0);
        end
        rst = 1'b0;
        for (int t = 1; t <= 105; t++) begin
            tick();
            chk("release sig_o p100", so[0], (t >= 102) ? 4'hF : 4'h0);
            chk("release rise_o p100", ro[0], (t == 102) ? 4'hF : 4'h0);
            chk("release rise_o p3", ro[1], (t == 5) ? 4'hF : 4'h0);
            chk("release rise_o p1", ro[2], (t == 3) ? 4'hF : 4'h0);
        end

        // Glitch of 99 cycles on channel 0 at Period 100.
        sig_i = 4'h0;
        repeat (110) tick();
        chk("settle low", so[0], 4'h0);
        sig_i = 4'h1;
        acc_r = '0;
        repeat (99) begin tick(); acc_r |= ro[0]; end
        sig_i = 4'h0;
        repeat (110) begin tick(); acc_r |= ro[0]; end
        chk("glitch rise_o p100", acc_r, 4'h0);
        chk("glitch sig_o p100", so[0], 4'h0);

        // Fall on channel 1.
        sig_i = 4'h2;
        repeat (110) tick();
        chk("fall setup", so[0], 4'h2);
        sig_i = 4'h0;
        for (int t = 1; t <= 103; t++) begin
            tick();
            if (t == 101) chk("fall early sig_o", so[0], 4'h2);
            if (t == 102) begin
                chk("fall sig_o", so[0], 4'h0);
                chk("fall fall_o", fo[0], 4'h2);
                chk("fall changed_o", co[0], 4'h2);
                chk("fall rise_o", ro[0], 4'h0);
            end
            if (t == 103) chk("fall pulse width", fo[0], 4'h0);
        end

        // Independent channels, ch2 at t and ch3 at t+10.
        sig_i = 4'h4;
        for (int t = 1; t <= 115; t++) begin
            tick();
            if (t == 10) sig_i = 4'hC;
            chk("indep rise_o p100", ro[0], (t == 102) ? 4'h4 : (t == 112) ? 4'h8 : 4'h0);
            chk("indep rise_o p1", ro[2], (t == 3) ? 4'h4 : (t == 13) ? 4'h8 : 4'h0);
        end

        // Reset in the middle of a count.
        sig_i = 4'h0;
        repeat (110) tick();
        sig_i = 4'h1;
        repeat (50) tick();
        rst = 1'b1;
        #1;
        for (int k = 0; k < NI; k++) chk("midreset async sig_o", so[k], 4'h0);
        repeat (3) begin
            tick();
            for (int k = 0; k < NI; k++) chk("midreset changed_o", co[k], 4'h0);
        end
        rst = 1'b0;
        for (int t = 1; t <= 103; t++) begin
            tick();
            chk("midreset rise_o p100", ro[0], (t == 102) ? 4'h1 : 4'h0);
            chk("midreset sig_o p100", so[0], (t >= 102) ? 4'h1 : 4'h0);
        end

`ifdef INPUT_COND_EVENT_LATCH_EN
        // Sticky event flag on the Period-1 instance.
        sig_i = 4'h0;
        repeat (110) tick();
        clear_i = 4'hF;
        tick();
        clear_i = 4'h0;
        chk("latch cleared", eo[2], 4'h0);
        sig_i = 4'h1;
        repeat (3) tick();
        chk("latch set rise", ro[2], 4'h1);
        chk("latch set", eo[2], 4'h1);
        repeat (5) tick();
        chk("latch sticky", eo[2], 4'h1);
        clear_i = 4'h1;
        tick();
        clear_i = 4'h0;
        chk("latch clear alone", eo[2], 4'h0);
        sig_i = 4'h0;
        repeat (2) tick();
        clear_i = 4'h1;
        tick();
        chk("latch fall pulse", fo[2], 4'h1);
        chk("latch set wins", eo[2], 4'h1);
        clear_i = 4'h0;
        tick();
        chk("latch held", eo[2], 4'h1);
`else
        for (int k = 0; k < NI; k++) chk("no latch event_o", eo[k], 4'h0);
`endif

        // Table-driven vectors against the Period-3 instance.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int r = 0; r < 12; r++) begin
            sig_i = tbl[r].in;
            acc_r = '0; acc_f = '0;
            for (int t = 0; t < tbl[r].hold; t++) begin
                tick();
                acc_r |= ro[1];
                acc_f |= fo[1];
            end
            chk($sformatf("vec%0d sig_o", r), so[1], tbl[r].exp_out);
            chk($sformatf("vec%0d rise_o", r), acc_r, tbl[r].exp_rise);
            chk($sformatf("vec%0d fall_o", r), acc_f, tbl[r].exp_fall);
        end

        // Random segments checked cycle by cycle against the model.
        for (int seg = 0; seg < 150; seg++) begin
            sig_i   = CH'($urandom);
            clear_i = CH'($urandom);
            if ($urandom_range(0, 39) == 0) begin
                rst = 1'b1;
                tick();
                rst = 1'b0;
            end
            hold = int'($urandom_range(1, 220));
            repeat (hold) tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
